// File: rtl/score_accum.sv
// score_accum -- per-hand modular card-score accumulator with a round FSM.
//
// The FSM states are IDLE, ACCUM and DONE. A start pulse clears every hand
// and opens a round. Cards go in through a valid/ready handshake. A close
// pulse ends the round, and the results hold until the next start.
//
// Optional feature: define SCORE_ACCUM_WINNER_EN to build the winner/tie
// comparator. When it is undefined, winner and tie are tied to 0.
//
// Parameters
//   NUM_HANDS  number of hands (2..8), hand 0 = player, 1 = dealer
//   MAX_CARDS  cards accepted per hand per round (1..15)
//   modulus    score modulus parameter MOD (10..16)
// Ports
//   slow_clock   clock; all state changes on the rising edge
//   resetb       asynchronous active-low reset
//   start        pulse: clear all hands, enter ACCUM (wins over close)
//   close        pulse: end round (ACCUM only)
//   card_valid   card_hand/card_value are valid
//   card_ready   card can be accepted this cycle (combinational)
//   card_hand    target hand index
//   card_value   raw code: 1 ace, 2..9 pips, 10..13 ten/face, others unused
//   totals       per-hand score, hand i at [4i+3:4i]
//   counts       per-hand accepted-card count, same packing
//   result_valid high in DONE
//   err          sticky: a card was taken for a nonexistent hand
//   winner       lowest index holding the maximum total
//   tie          maximum total is shared

module score_hand #(
  parameter int MAX_CARDS = 3,
  parameter int MOD       = 10
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] weight,
  output logic [3:0] total,
  output logic [3:0] count,
  output logic [3:0] nxt,
  output logic       full
);
  logic [4:0] sum;
  logic [3:0] wrapped;

  // total < MOD and weight <= 9 < MOD, so a single subtract always lands in range
  always_comb begin
    sum     = {1'b0, total} + {1'b0, weight};
    wrapped = (sum >= 5'(MOD)) ? 4'(sum - 5'(MOD)) : sum[3:0];
    nxt     = clr ? 4'd0 : (inc ? wrapped : total);
  end

  assign full = (count >= 4'(MAX_CARDS));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      total <= '0;
      count <= '0;
    end else begin
      total <= nxt;
      if (clr)      count <= '0;
      else if (inc) count <= count + 4'd1;
    end
  end
endmodule

module score_accum #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  parameter int MOD       = 10
) (
  input  logic                   slow_clock,
  input  logic                   resetb,
  input  logic                   start,
  input  logic                   close,
  input  logic                   card_valid,
  output logic                   card_ready,
  input  logic [2:0]             card_hand,
  input  logic [3:0]             card_value,
  output logic [4*NUM_HANDS-1:0] totals,
  output logic [4*NUM_HANDS-1:0] counts,
  output logic                   result_valid,
  output logic                   err,
  output logic [2:0]             winner,
  output logic                   tie
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t st, st_nxt;

  logic [NUM_HANDS-1:0][3:0] tot_a, cnt_a;
  logic [NUM_HANDS-1:0]      full_a, inc_a;
  logic [7:0]                full_ext;
  logic                      legal, xfer;
  logic [3:0]                weight;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) st <= IDLE;
    else         st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (start)                     st_nxt = ACCUM;
    else if (st == ACCUM && close) st_nxt = DONE;
  end

  // Pad the full flags to 8 entries so that any 3-bit hand index can be
  // looked up. Out-of-range hands are never full, so their cards are
  // accepted and flagged as errors.
  always_comb begin
    full_ext                = '0;
    full_ext[NUM_HANDS-1:0] = full_a;
  end

  assign legal      = ({1'b0, card_hand} < 4'(NUM_HANDS));
  assign card_ready = (st == ACCUM) && !start && (!legal || !full_ext[card_hand]);
  assign xfer       = card_valid && card_ready;
  assign weight     = (card_value >= 4'd1 && card_value <= 4'd9) ? card_value : 4'd0;

`ifdef SCORE_ACCUM_WINNER_EN
  logic [NUM_HANDS-1:0][3:0] nxt_a;
`endif

  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
    assign inc_a[h] = xfer && legal && (card_hand == 3'(h));
    score_hand #(.MAX_CARDS(MAX_CARDS), .MOD(MOD)) u_hand (
      .gclk   (slow_clock),
      .grst_n (resetb),
      .clr    (start),
      .inc    (inc_a[h]),
      .weight (weight),
      .total  (tot_a[h]),
      .count  (cnt_a[h]),
`ifdef SCORE_ACCUM_WINNER_EN
      .nxt    (nxt_a[h]),
`else
      .nxt    (),
`endif
      .full   (full_a[h])
    );
  end

  assign totals       = tot_a;
  assign counts       = cnt_a;
  assign result_valid = (st == DONE);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)                 err <= 1'b0;
    else if (start)              err <= 1'b0;
    else if (xfer && !legal)     err <= 1'b1;
  end

`ifdef SCORE_ACCUM_WINNER_EN
  logic [3:0] best;
  logic [2:0] widx;
  logic       wtie;

  // Rank the post-edge totals so that a card taken in the same cycle as
  // close is part of the result. A strict '>' keeps the lowest index on ties.
  always_comb begin
    best = nxt_a[0];
    widx = 3'd0;
    wtie = 1'b0;
    for (int i = 1; i < NUM_HANDS; i++) begin
      if (nxt_a[i] > best) begin
        best = nxt_a[i];
        widx = 3'(i);
        wtie = 1'b0;
      end else if (nxt_a[i] == best) begin
        wtie = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      winner <= '0;
      tie    <= 1'b0;
    end else if (start) begin
      winner <= '0;
      tie    <= 1'b0;
    end else if (st == ACCUM && close) begin
      winner <= widx;
      tie    <= wtie;
    end
  end
`else
  assign winner = '0;
  assign tie    = 1'b0;
`endif
endmodule

// File: tb/tb_score_accum.sv
module tb_score_accum;
  localparam int NH = 2, MC = 3, MD = 10;
`ifdef SCORE_ACCUM_WINNER_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic clk = 1'b0, resetb;
  logic start, close, card_valid, card_ready, result_valid, err, tie;
  logic [2:0] card_hand, winner;
  logic [3:0] card_value;
  logic [4*NH-1:0] totals, counts;

  always #5 clk = ~clk;

  score_accum #(.NUM_HANDS(NH), .MAX_CARDS(MC), .MOD(MD)) dut (
    .slow_clock(clk), .resetb(resetb), .start(start), .close(close),
    .card_valid(card_valid), .card_ready(card_ready), .card_hand(card_hand),
    .card_value(card_value), .totals(totals), .counts(counts),
    .result_valid(result_valid), .err(err), .winner(winner), .tie(tie));

  int passed = 0, total_chk = 0;

  // Reference model: round mode 0 idle, 1 open, 2 finished.
  int m_tot[NH], m_cnt[NH], m_mode, m_win;
  bit m_err, m_tie;

  task automatic chk(string name, int act, int exp);
    total_chk++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic m_clear(int mode);
    for (int i = 0; i < NH; i++) begin m_tot[i] = 0; m_cnt[i] = 0; end
    m_err = 0; m_win = 0; m_tie = 0; m_mode = mode;
  endtask

  function automatic bit m_ready(bit s, int h);
    return m_mode == 1 && !s && (h >= NH || m_cnt[h] < MC);
  endfunction

  task automatic m_update(bit s, bit c, bit v, int h, int val);
    bit rdy;
    int best, n;
    rdy = m_ready(s, h);
    if (s) m_clear(1);
    else if (m_mode == 1) begin
      if (v && rdy) begin
        if (h < NH) begin
          m_tot[h] = (m_tot[h] + ((val >= 1 && val <= 9) ? val : 0)) % MD;
          m_cnt[h]++;
        end else m_err = 1;
      end
      if (c) begin
        m_mode = 2;
        if (WEN) begin
          best = -1; n = 0;
          for (int i = 0; i < NH; i++) if (m_tot[i] > best) begin best = m_tot[i]; m_win = i; end
          for (int i = 0; i < NH; i++) if (m_tot[i] == best) n++;
          m_tie = (n > 1);
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < NH; i++) begin
      chk($sformatf("%s total[%0d]", tag, i), int'(totals[4*i +: 4]), m_tot[i]);
      chk($sformatf("%s count[%0d]", tag, i), int'(counts[4*i +: 4]), m_cnt[i]);
    end
    chk({tag, " result_valid"}, int'(result_valid), int'(m_mode == 2));
    chk({tag, " err"}, int'(err), int'(m_err));
    chk({tag, " winner"}, int'(winner), m_win);
    chk({tag, " tie"}, int'(tie), int'(m_tie));
  endtask

  // Called at posedge+1: drive inputs, sample ready before the edge,
  // advance the model at the edge, and compare just after it.
  task automatic step(string tag, bit s, bit c, bit v, int h, int val, output bit rdy_s);
    start = s; close = c; card_valid = v; card_hand = 3'(h); card_value = 4'(val);
    #2;
    rdy_s = card_ready;
    chk({tag, " card_ready"}, int'(card_ready), int'(m_ready(s, h)));
    @(posedge clk);
    m_update(s, c, v, h, val);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit s, c, v; int h, val;
    bit rdy; int t0, t1, c0, c1; bit rv, er; int win; bit tie;
  } vec_t;
  vec_t tbl[$];

  initial begin
    bit r;
    bit cv; int ch, cval;
    resetb = 1'b0; start = 0; close = 0; card_valid = 0; card_hand = 0; card_value = 0;
    m_clear(0);
    #12;
    check_all("reset");
    chk("reset card_ready", int'(card_ready), 0);
    @(posedge clk); #1;
    resetb = 1'b1;

    //              s c v h val rdy t0 t1 c0 c1 rv er win tie
    tbl.push_back('{0,0,1,0, 5, 0,  0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1,0,0,0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 7, 1,  7, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 8, 1,  5, 0, 2, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,1,13, 1,  5, 0, 2, 1, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,1, 4, 1,  5, 4, 2, 2, 0, 0, 0, 0});
    tbl.push_back('{0,1,0,0, 0, 1,  5, 4, 2, 2, 1, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 3, 0,  5, 4, 2, 2, 1, 0, 0, 0});
    tbl.push_back('{0,1,0,0, 0, 0,  5, 4, 2, 2, 1, 0, 0, 0});
    tbl.push_back('{1,0,0,0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 9, 1,  9, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 9, 1,  8, 0, 2, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 9, 1,  7, 0, 3, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 9, 0,  7, 0, 3, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,1, 2, 1,  7, 2, 3, 1, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,5, 6, 1,  7, 2, 3, 1, 0, 1, 0, 0});
    tbl.push_back('{1,0,0,0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 3, 1,  3, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1,0,1,0, 4, 0,  0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,1,1,1,10, 1,  0, 0, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{1,1,0,0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,0, 6, 1,  6, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,1, 6, 1,  6, 6, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{0,1,0,0, 0, 1,  6, 6, 1, 1, 1, 0, 0, 1});
    tbl.push_back('{1,0,0,0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,0,1,1, 9, 1,  0, 9, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0,1,0,0, 0, 1,  0, 9, 0, 1, 1, 0, 1, 0});

    foreach (tbl[k]) begin
      string t;
      t = $sformatf("vec%0d", k);
      step(t, tbl[k].s, tbl[k].c, tbl[k].v, tbl[k].h, tbl[k].val, r);
      chk({t, " tbl ready"}, int'(r), int'(tbl[k].rdy));
      chk({t, " tbl t0"}, int'(totals[3:0]), tbl[k].t0);
      chk({t, " tbl t1"}, int'(totals[7:4]), tbl[k].t1);
      chk({t, " tbl c0"}, int'(counts[3:0]), tbl[k].c0);
      chk({t, " tbl c1"}, int'(counts[7:4]), tbl[k].c1);
      chk({t, " tbl rv"}, int'(result_valid), int'(tbl[k].rv));
      chk({t, " tbl err"}, int'(err), int'(tbl[k].er));
      chk({t, " tbl winner"}, int'(winner), WEN ? tbl[k].win : 0);
      chk({t, " tbl tie"}, int'(tie), int'(WEN && tbl[k].tie));
    end

    // Asynchronous reset in the middle of a round, away from any clock edge
    step("rst_a", 1, 0, 0, 0, 0, r);
    step("rst_b", 0, 0, 1, 0, 3, r);
    chk("rst hand0 pre", int'(totals[3:0]), 3);
    card_valid = 1; card_hand = 0; card_value = 4;
    #3;
    resetb = 1'b0;
    m_clear(0);
    #1;
    check_all("async_rst");
    chk("async_rst card_ready", int'(card_ready), 0);
    @(posedge clk); #1;
    resetb = 1'b1;
    step("post_rst_card", 0, 0, 1, 0, 4, r);
    step("post_rst_start", 1, 0, 0, 0, 0, r);
    step("post_rst_card2", 0, 0, 1, 0, 4, r);
    chk("post_rst hand0", int'(totals[3:0]), 4);

    // Random traffic; an offered card stays put until it is taken
    cv = 0; ch = 0; cval = 0;
    for (int n = 0; n < 400; n++) begin
      bit s, c, rd;
      s = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 11) == 0);
      if (!cv) begin
        cv = ($urandom_range(0, 9) < 7);
        ch = $urandom_range(0, 3);
        cval = $urandom_range(0, 15);
      end
      rd = m_ready(s, ch);
      step("rand", s, c, cv, ch, cval, r);
      if (cv && rd) cv = 0;
    end

    $display("%0d/%0d checks passed", passed, total_chk);
    $finish;
  end
endmodule
